// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns (active-low a..g, index 0 = a) and FSM encoding
// for the seg7_decoder slice.
package seg7_pkg;

    localparam logic [0:6] SEG7_BLANK = 7'b1111111;

    localparam logic [0:6] SEG7_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        LOCKED,
        SETTLING
    } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: combinational classification of a segment pattern into
// hex digit / blank / unknown.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic       is_hex,
    output logic       is_blank,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_TABLE[i]) begin
                is_hex = 1'b1;
                nibble = 4'(i);
            end
        end
        is_blank = pattern == SEG7_BLANK;
    end

endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: synchronise, debounce and decode an active-low 7-segment bus to hex.
// Optional +1 (mod 16) digit order check enabled by defining SEG7_SEQ_CHECK_EN.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [0:6]       SEG_IN,
    output logic [3:0]       VALUE,
    output logic             VALID,
    output logic             BLANK,
    output logic             ERR,
    output logic [CNT_W-1:0] DIGIT_CNT,
    output logic             SEQ_ERR
);

    logic [0:6]  sync_q [SYNC_STAGES];
    logic [0:6]  synced;
    logic [0:6]  acc, pend, pend_nx;
    logic [7:0]  stab_cnt, cnt_nx;
    seg7_state_t state, state_nx;
    logic        accept;
    logic        is_hex, is_blank;
    logic [3:0]  nibble;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SEG7_BLANK;
        end else begin
            sync_q[0] <= SEG_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Accepted pattern equals synced at the accept cycle, so classify synced directly.
    seg7_pattern_lookup u_lookup (
        .pattern  (synced),
        .is_hex   (is_hex),
        .is_blank (is_blank),
        .nibble   (nibble)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= LOCKED;
            stab_cnt <= 8'd0;
            pend     <= SEG7_BLANK;
            acc      <= SEG7_BLANK;
        end else begin
            state    <= state_nx;
            stab_cnt <= cnt_nx;
            pend     <= pend_nx;
            acc      <= accept ? synced : acc;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = stab_cnt;
        pend_nx  = pend;
        accept   = 1'b0;
        if (state == LOCKED) begin
            if (synced != acc) begin
                state_nx = SETTLING;
                cnt_nx   = 8'd0;
                pend_nx  = synced;
            end
        end else if (synced == acc) begin
            state_nx = LOCKED;
        end else if (synced != pend) begin
            pend_nx = synced;
            cnt_nx  = 8'd0;
        end else if (stab_cnt == 8'(STABLE_CYCLES - 1)) begin
            accept   = 1'b1;
            state_nx = LOCKED;
        end else begin
            cnt_nx = stab_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            VALUE     <= 4'd0;
            VALID     <= 1'b0;
            BLANK     <= 1'b1;
            ERR       <= 1'b0;
            DIGIT_CNT <= '0;
        end else begin
            VALID <= accept && is_hex;
            ERR   <= accept && !is_hex && !is_blank;
            if (accept && is_hex) begin
                VALUE     <= nibble;
                BLANK     <= 1'b0;
                DIGIT_CNT <= DIGIT_CNT + CNT_W'(1);
            end else if (accept && is_blank) begin
                BLANK <= 1'b1;
            end
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    logic have_prev;

    // VALUE still holds the previous digit in the accept cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            have_prev <= 1'b0;
            SEQ_ERR   <= 1'b0;
        end else begin
            SEQ_ERR <= accept && is_hex && have_prev && (nibble != VALUE + 4'd1);
            if (accept && is_hex) have_prev <= 1'b1;
        end
    end
`else
    assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed tests of seg7_decoder with default parameters.
module tb_seg7_decoder;

    localparam int LAT = 2 + 4 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:6] seg = 7'b1111111;
    logic [3:0] value;
    logic       valid, blank, err, seq_err;
    logic [7:0] digit_cnt;

    int errors = 0;
    int checks = 0;
    int n_valid = 0, n_err = 0, n_seq = 0, n_orphan = 0;
    int exp_seq;
    logic [7:0] exp_cnt;

    logic [0:6] pats [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_decoder dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .SEG_IN    (seg),
        .VALUE     (value),
        .VALID     (valid),
        .BLANK     (blank),
        .ERR       (err),
        .DIGIT_CNT (digit_cnt),
        .SEQ_ERR   (seq_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (err) n_err++;
        if (seq_err) begin
            n_seq++;
            if (!valid) n_orphan++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_valid = 0; n_err = 0; n_seq = 0; n_orphan = 0;
    endtask

    task automatic show(input logic [0:6] p, input int n);
        seg = p;
        tick(n);
    endtask

    task automatic test_reset();
        checks++; if (value !== 4'd0) begin errors++; $display("FAIL rst_value: got %0d want 0", value); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rst_blank: got %0b want 1", blank); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", valid); end
        rst_n = 1'b1;
        clear_counts();
        show(7'b1111111, 50);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL idle_blank: got %0b want 1", blank); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", n_valid); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL idle_err: got %0d pulses want 0", n_err); end
        checks++; if (digit_cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt: got %0d want 0", digit_cnt); end
    endtask

    task automatic test_latency();
        int first;
        first = -1;
        clear_counts();
        seg = pats[2];
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (valid && first < 0) first = k;
        end
        #1;
        checks++; if (first !== LAT) begin errors++; $display("FAIL latency: got %0d want %0d", first, LAT); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL lat_pulses: got %0d want 1", n_valid); end
        checks++; if (value !== 4'd2) begin errors++; $display("FAIL lat_value: got %0d want 2", value); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL lat_blank: got %0b want 0", blank); end
        checks++; if (digit_cnt !== 8'd1) begin errors++; $display("FAIL lat_cnt: got %0d want 1", digit_cnt); end
    endtask

    task automatic test_glitch();
        show(pats[3], 12);
        checks++; if (value !== 4'd3) begin errors++; $display("FAIL glitch_pre: got %0d want 3", value); end
        clear_counts();
        show(pats[1], 2);
        show(pats[3], 14);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses want 0", n_valid); end
        checks++; if (value !== 4'd3) begin errors++; $display("FAIL glitch_value: got %0d want 3", value); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL glitch_err: got %0d pulses want 0", n_err); end
    endtask

    task automatic test_unknown();
        clear_counts();
        show(7'b1010101, 30);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL unk_err: got %0d pulses want 1", n_err); end
        checks++; if (value !== 4'd3) begin errors++; $display("FAIL unk_value: got %0d want 3", value); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL unk_blank: got %0b want 0", blank); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL unk_valid: got %0d pulses want 0", n_valid); end
        checks++; if (digit_cnt !== 8'd2) begin errors++; $display("FAIL unk_cnt: got %0d want 2", digit_cnt); end
    endtask

    task automatic test_sequence();
        rst_n = 1'b0;
        seg = 7'b1111111;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        clear_counts();
        for (int i = 0; i < 17; i++) show(pats[i % 16], 10);
        exp_cnt = 8'd17;
        checks++; if (n_valid !== 17) begin errors++; $display("FAIL seq_valids: got %0d want 17", n_valid); end
        checks++; if (n_seq !== 0) begin errors++; $display("FAIL seq_clean: got %0d pulses want 0", n_seq); end
        checks++; if (value !== 4'd0) begin errors++; $display("FAIL seq_value: got %0d want 0", value); end
        checks++; if (digit_cnt !== exp_cnt) begin errors++; $display("FAIL seq_cnt: got %0d want %0d", digit_cnt, exp_cnt); end
        clear_counts();
        show(pats[5], 10);
        exp_cnt++;
`ifdef SEG7_SEQ_CHECK_EN
        exp_seq = 1;
`else
        exp_seq = 0;
`endif
        checks++; if (n_seq !== exp_seq) begin errors++; $display("FAIL seq_jump: got %0d pulses want %0d", n_seq, exp_seq); end
        checks++; if (n_orphan !== 0) begin errors++; $display("FAIL seq_align: got %0d pulses without VALID want 0", n_orphan); end
        checks++; if (value !== 4'd5) begin errors++; $display("FAIL seq_v5: got %0d want 5", value); end
        clear_counts();
        show(7'b1111111, 10);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_set: got %0b want 1", blank); end
        checks++; if (value !== 4'd5) begin errors++; $display("FAIL blank_hold: got %0d want 5", value); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL blank_valid: got %0d pulses want 0", n_valid); end
        show(pats[5], 10);
        exp_cnt++;
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL repeat_valid: got %0d pulses want 1", n_valid); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL repeat_blank: got %0b want 0", blank); end
        checks++; if (digit_cnt !== exp_cnt) begin errors++; $display("FAIL repeat_cnt: got %0d want %0d", digit_cnt, exp_cnt); end
        checks++; if (n_seq !== exp_seq) begin errors++; $display("FAIL repeat_seq: got %0d pulses want %0d", n_seq, exp_seq); end
    endtask

    task automatic test_wrap();
        int need;
        need = 256 - int'(exp_cnt);
        clear_counts();
        for (int i = 0; i < need; i++) show(pats[8 + (i % 2)], 8);
        checks++; if (n_valid !== need) begin errors++; $display("FAIL wrap_valids: got %0d want %0d", n_valid, need); end
        checks++; if (digit_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt: got %0d want 0", digit_cnt); end
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        clear_counts();
        seg = pats[15];
        tick(3);
        rst_n = 1'b0;
        tick(2);
        checks++; if (value !== 4'd0) begin errors++; $display("FAIL mid_value: got %0d want 0", value); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL mid_blank: got %0b want 1", blank); end
        checks++; if (digit_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", digit_cnt); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL mid_pulse: got %0d pulses want 0", n_valid); end
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (valid && first < 0) first = k;
        end
        #1;
        checks++; if (first !== LAT) begin errors++; $display("FAIL mid_latency: got %0d want %0d", first, LAT); end
        checks++; if (value !== 4'hF) begin errors++; $display("FAIL mid_valueF: got %0d want 15", value); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL mid_err: got %0d pulses want 0", n_err); end
        checks++; if (digit_cnt !== 8'd1) begin errors++; $display("FAIL mid_cnt_after: got %0d want 1", digit_cnt); end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_latency();
        test_glitch();
        test_unknown();
        test_sequence();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
